// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/halt/single-step sequencer driving core_rst/core_en of the single-cycle core.
// Breakpoint halting is built only when CORE_RUN_CTRL_BREAKPOINT_EN is defined.
module core_run_ctrl #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             bp_valid_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    output logic             core_rst_o,
    output logic             core_en_o,
    output logic             halted_o,
    output logic [1:0]       halt_cause_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
    localparam logic [1:0] OP_RUN = 2'b00, OP_HALT = 2'b01, OP_STEP = 2'b10, OP_CLR = 2'b11;
    typedef enum logic [1:0] {S_HOLD, S_HALT, S_RUN, S_STEP} state_t;
    state_t            state_q;
    logic [HW-1:0]     hold_cnt_q;
    logic [1:0]        cause_q;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              bp_mask_q;
    logic              bp_hit;
    logic              accept;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    // The mask lets the first instruction after a resume run even if it sits on the breakpoint.
    assign bp_hit = state_q == S_RUN && bp_valid_i && pc_i == bp_addr_i && !bp_mask_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_valid_i, bp_addr_i, bp_mask_q};
    assign bp_hit    = 1'b0;
`endif
    assign core_rst_o   = state_q == S_HOLD;
    assign halted_o     = state_q == S_HALT;
    assign cmd_ready_o  = state_q == S_HALT || state_q == S_RUN;
    assign core_en_o    = state_q == S_STEP || (state_q == S_RUN && !bp_hit);
    assign accept       = cmd_valid_i && cmd_ready_o;
    assign halt_cause_o = cause_q;
    assign retired_o    = retired_q;
    always_comb begin
        retired_d = (accept && cmd_op_i == OP_CLR) ? '0 :
                    (core_en_o && !(&retired_q))   ? retired_q + 1'b1 : retired_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= HW'(RESET_HOLD - 1);
            cause_q    <= 2'b00;
            retired_q  <= '0;
            bp_mask_q  <= 1'b0;
        end else begin
            retired_q <= retired_d;
            bp_mask_q <= state_q == S_HALT && accept && !cmd_op_i[0];
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == '0) state_q <= S_HALT;
                    else hold_cnt_q <= hold_cnt_q - 1'b1;
                end
                S_HALT: begin
                    if (accept && cmd_op_i == OP_RUN) state_q <= S_RUN;
                    else if (accept && cmd_op_i == OP_STEP) state_q <= S_STEP;
                end
                S_RUN: begin
                    if (bp_hit) begin
                        state_q <= S_HALT;
                        cause_q <= 2'b11;
                    end else if (accept && cmd_op_i == OP_HALT) begin
                        state_q <= S_HALT;
                        cause_q <= 2'b01;
                    end
                end
                default: begin
                    state_q <= S_HALT;
                    cause_q <= 2'b10;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed scoreboard bench; every entry into HALT is checked against a queued expectation.
module tb_core_run_ctrl;
    localparam logic [1:0] RUN = 2'b00, HALT = 2'b01, STEP = 2'b10, CLR = 2'b11;
    typedef struct {
        int cause;
        int ret;
        int pc;
        int en;
        int rst;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] pc = '0;
    logic        bp_valid;
    logic [31:0] bp_addr;
    logic        core_rst, core_en, halted;
    logic [1:0]  halt_cause;
    logic [7:0]  retired;
    exp_t        q[$];
    int          compared = 0, mismatched = 0;
    int          en_cnt = 0, rst_cnt = 0, ev = 0;
    logic        prev_h = 1'b0;

    core_run_ctrl #(.PC_W(32), .CNT_W(8), .RESET_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .pc_i(pc), .bp_valid_i(bp_valid), .bp_addr_i(bp_addr),
        .core_rst_o(core_rst), .core_en_o(core_en), .halted_o(halted),
        .halt_cause_o(halt_cause), .retired_o(retired)
    );

    always #5 clk = ~clk;

    // PC+1 core: PC advances only when enabled, clears under core_rst.
    always @(posedge clk) pc <= core_rst ? 32'd0 : core_en ? pc + 32'd1 : pc;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void push(input int c, input int r, input int p, input int e, input int s);
        exp_t x;
        x.cause = c; x.ret = r; x.pc = p; x.en = e; x.rst = s;
        q.push_back(x);
    endfunction

    task automatic send(input logic [1:0] op);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            compared++;
            mismatched++;
            $display("FAIL cmd_timeout: op %0d not accepted within %0d cycles", op, n);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Monitor: counts enable/reset cycles and checks state on every entry into HALT.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                en_cnt  = 0;
                rst_cnt = 0;
                prev_h  = 1'b0;
            end else begin
                if (halted && !prev_h) begin
                    ev++;
                    if (q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_halt e%0d: got halt entry, expected none", ev);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk($sformatf("e%0d_cause", ev), int'(halt_cause), e.cause);
                        chk($sformatf("e%0d_retired", ev), int'(retired), e.ret);
                        chk($sformatf("e%0d_pc", ev), int'(pc), e.pc);
                        chk($sformatf("e%0d_en_cycles", ev), en_cnt, e.en);
                        chk($sformatf("e%0d_rst_cycles", ev), rst_cnt, e.rst);
                    end
                    en_cnt  = 0;
                    rst_cnt = 0;
                end
                en_cnt  += int'(core_en);
                rst_cnt += int'(core_rst);
                prev_h  = halted;
            end
        end
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = RUN; bp_valid = 1'b0; bp_addr = '0;
        push(0, 0, 0, 0, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        push(2, 1, 1, 1, 0); push(2, 2, 2, 1, 0); push(2, 3, 3, 1, 0);
        repeat (3) send(STEP);
        send(CLR);
        push(1, 10, 13, 10, 0);
        send(RUN);
        repeat (9) @(posedge clk);
        send(HALT);
        push(1, 1, 15, 2, 0);
        send(RUN);
        send(CLR);
        send(HALT);
        push(1, 255, 315, 300, 0);
        send(RUN);
        repeat (299) @(posedge clk);
        send(HALT);
        push(0, 0, 0, 0, 4);
        send(RUN);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        repeat (6) @(posedge clk);
        bp_valid = 1'b1;
        bp_addr  = 32'd5;
        push(3, 5, 5, 5, 0);
        send(RUN);
        push(1, 8, 8, 3, 0);
        send(RUN);
        repeat (2) @(posedge clk);
        send(HALT);
        bp_addr = 32'd10;
        push(3, 10, 10, 2, 0);
        send(RUN);
        repeat (2) @(posedge clk);
        send(HALT);
`endif
        repeat (2) @(negedge clk);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL pending_halts: got %0d unmatched expectations, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
